morse_key_decoder: RTL and testbench

Parametrised Morse receiver that turns a raw key level into ASCII characters. It times marks and spaces against a configurable unit length, classifies each mark as a dot or a dash and each space as an intra-letter, letter or word gap, then decodes letters, and optionally digits, through a lookup. Decoded characters go out through a single-entry valid/ready register to the downstream UART/display path. Error and overrun flags cover malformed input and backpressure.

---
 rtl/morse_key_decoder.sv | 172 +++++++++++++++++
 tb/tb_morse_key_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: times key marks/spaces against a unit length and decodes Morse to ASCII
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   key_in                synchronised key level, 1 = mark
//   out_ready             downstream accepts out_char this cycle
//   out_valid, out_char   single-entry output register holding an unconsumed character
//   out_err               out_char is '?' for an unknown or overflowed pattern
//   overrun               sticky; a character was dropped while the output was full
//   busy                  symbols of the current letter are accumulated
module morse_key_decoder #(
    parameter int UNIT_CYCLES   = 1000,
    parameter int CNT_W         = 16,
    parameter int MAX_SYMS      = 6,
    parameter bit ENABLE_DIGITS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic       out_err,
    output logic       overrun,
    output logic       busy
);
    localparam logic [CNT_W-1:0] GLITCH_LT = CNT_W'(UNIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_AT = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_AT   = CNT_W'(7 * UNIT_CYCLES - 1);
    localparam logic [3:0]       MAX_LEN   = 4'(MAX_SYMS);

    logic                key_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MAX_SYMS-1:0] pat_q, pat_d;
    logic [3:0]          len_q, len_d;
    logic                ovf_q, ovf_d;
    logic                letter_seen_q, letter_seen_d;
    logic                word_done_q, word_done_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_char_q, out_char_d;
    logic                out_err_q, out_err_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          lut_char, emit_char;
    logic                mark_end, letter_end, word_end, emit, emit_err;

    // Pattern bits above len are always zero, so (len, pattern) indexes the table directly.
    always_comb begin
        lut_char = 8'h00;
        case ({len_q, 8'(pat_q)})
            {4'd2, 8'b01}:    lut_char = "A";
            {4'd4, 8'b1000}:  lut_char = "B";
            {4'd4, 8'b1010}:  lut_char = "C";
            {4'd3, 8'b100}:   lut_char = "D";
            {4'd1, 8'b0}:     lut_char = "E";
            {4'd4, 8'b0010}:  lut_char = "F";
            {4'd3, 8'b110}:   lut_char = "G";
            {4'd4, 8'b0000}:  lut_char = "H";
            {4'd2, 8'b00}:    lut_char = "I";
            {4'd4, 8'b0111}:  lut_char = "J";
            {4'd3, 8'b101}:   lut_char = "K";
            {4'd4, 8'b0100}:  lut_char = "L";
            {4'd2, 8'b11}:    lut_char = "M";
            {4'd2, 8'b10}:    lut_char = "N";
            {4'd3, 8'b111}:   lut_char = "O";
            {4'd4, 8'b0110}:  lut_char = "P";
            {4'd4, 8'b1101}:  lut_char = "Q";
            {4'd3, 8'b010}:   lut_char = "R";
            {4'd3, 8'b000}:   lut_char = "S";
            {4'd1, 8'b1}:     lut_char = "T";
            {4'd3, 8'b001}:   lut_char = "U";
            {4'd4, 8'b0001}:  lut_char = "V";
            {4'd3, 8'b011}:   lut_char = "W";
            {4'd4, 8'b1001}:  lut_char = "X";
            {4'd4, 8'b1011}:  lut_char = "Y";
            {4'd4, 8'b1100}:  lut_char = "Z";
            {4'd5, 8'b11111}: lut_char = ENABLE_DIGITS ? "0" : 8'h00;
            {4'd5, 8'b01111}: lut_char = ENABLE_DIGITS ? "1" : 8'h00;
            {4'd5, 8'b00111}: lut_char = ENABLE_DIGITS ? "2" : 8'h00;
            {4'd5, 8'b00011}: lut_char = ENABLE_DIGITS ? "3" : 8'h00;
            {4'd5, 8'b00001}: lut_char = ENABLE_DIGITS ? "4" : 8'h00;
            {4'd5, 8'b00000}: lut_char = ENABLE_DIGITS ? "5" : 8'h00;
            {4'd5, 8'b10000}: lut_char = ENABLE_DIGITS ? "6" : 8'h00;
            {4'd5, 8'b11000}: lut_char = ENABLE_DIGITS ? "7" : 8'h00;
            {4'd5, 8'b11100}: lut_char = ENABLE_DIGITS ? "8" : 8'h00;
            {4'd5, 8'b11110}: lut_char = ENABLE_DIGITS ? "9" : 8'h00;
            default:          lut_char = 8'h00;
        endcase
    end

    // Thresholds use equality so a saturated counter can never fire them again.
    assign mark_end   = key_q && !key_in && cnt_q >= GLITCH_LT;
    assign letter_end = !key_q && !key_in && cnt_q == LETTER_AT && (len_q != 4'd0 || ovf_q);
    assign word_end   = !key_q && !key_in && cnt_q == WORD_AT && letter_seen_q && !word_done_q;
    assign emit       = letter_end || word_end;
    assign emit_err   = letter_end && (ovf_q || lut_char == 8'h00);
    assign emit_char  = word_end ? 8'h20 : emit_err ? 8'h3F : lut_char;

    always_comb begin
        cnt_d         = key_in != key_q ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + 1'b1;
        pat_d         = pat_q;
        len_d         = len_q;
        ovf_d         = ovf_q;
        letter_seen_d = letter_seen_q;
        word_done_d   = word_done_q;
        out_valid_d   = out_valid_q;
        out_char_d    = out_char_q;
        out_err_d     = out_err_q;
        overrun_d     = overrun_q;
        if (mark_end) begin
            if (len_q == MAX_LEN) begin
                ovf_d = 1'b1;
            end else begin
                pat_d = {pat_q[MAX_SYMS-2:0], cnt_q >= DASH_MIN};
                len_d = len_q + 4'd1;
            end
        end
        if (letter_end) begin
            pat_d         = '0;
            len_d         = 4'd0;
            ovf_d         = 1'b0;
            letter_seen_d = 1'b1;
            word_done_d   = 1'b0;
        end
        if (word_end) begin
            letter_seen_d = 1'b0;
            word_done_d   = 1'b1;
        end
        if (emit && (!out_valid_q || out_ready)) begin
            out_valid_d = 1'b1;
            out_char_d  = emit_char;
            out_err_d   = emit_err;
        end else if (emit) begin
            overrun_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q         <= 1'b0;
            cnt_q         <= '0;
            pat_q         <= '0;
            len_q         <= 4'd0;
            ovf_q         <= 1'b0;
            letter_seen_q <= 1'b0;
            word_done_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_char_q    <= 8'h00;
            out_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            key_q         <= key_in;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            len_q         <= len_d;
            ovf_q         <= ovf_d;
            letter_seen_q <= letter_seen_d;
            word_done_q   <= word_done_d;
            out_valid_q   <= out_valid_d;
            out_char_q    <= out_char_d;
            out_err_q     <= out_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign out_err   = out_err_q;
    assign overrun   = overrun_q;
    assign busy      = len_q != 4'd0;
endmodule

// File: tb/tb_morse_key_decoder.sv
// tb_morse_key_decoder: directed Morse stimulus against two decoders (digits on/off) and a string-level model
module tb_morse_key_decoder;
    localparam int U = 4;
    localparam int MS = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key = 1'b0;
    logic       rdy = 1'b0;
    logic       out_valid, out_err, overrun, busy;
    logic [7:0] out_char;
    logic       nd_valid, nd_err, nd_overrun, nd_busy;
    logic [7:0] nd_char;

    int errors = 0;
    int checks = 0;

    morse_key_decoder #(.UNIT_CYCLES(U), .CNT_W(8), .MAX_SYMS(MS), .ENABLE_DIGITS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key), .out_ready(rdy),
        .out_valid(out_valid), .out_char(out_char), .out_err(out_err),
        .overrun(overrun), .busy(busy)
    );

    morse_key_decoder #(.UNIT_CYCLES(U), .CNT_W(8), .MAX_SYMS(MS), .ENABLE_DIGITS(1'b0)) dut_nd (
        .clk(clk), .rst_n(rst_n), .key_in(key), .out_ready(rdy),
        .out_valid(nd_valid), .out_char(nd_char), .out_err(nd_err),
        .overrun(nd_overrun), .busy(nd_busy)
    );

    always #5 clk = ~clk;

    string codes [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                          "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                          "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                          "---..", "----."};

    int         run = 0;
    logic       lvl = 1'b0;
    string      syms = "";
    logic       armed = 1'b0;
    logic       mv = 1'b0, me = 1'b0, men = 1'b0, mo = 1'b0;
    logic [7:0] mc = 8'h00, mcn = 8'h00;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] decode(input string s, input bit digits);
        if (s.len() <= MS)
            for (int i = 0; i < (digits ? 36 : 26); i++)
                if (codes[i] == s) return {1'b0, i < 26 ? 8'(65 + i) : 8'(48 + i - 26)};
        return {1'b1, 8'h3F};
    endfunction

    task automatic model_reset();
        run = 0; lvl = 1'b0; syms = ""; armed = 1'b0;
        mv = 1'b0; me = 1'b0; men = 1'b0; mo = 1'b0; mc = 8'h00; mcn = 8'h00;
    endtask

    task automatic model_step();
        logic [8:0] r, rn;
        bit emit = 1'b0;
        r = '0;
        rn = '0;
        if (key != lvl) begin
            if (lvl && run >= U / 2) begin
                if (run >= 2 * U) syms = {syms, "-"};
                else syms = {syms, "."};
            end
            lvl = key;
            run = 1;
        end else begin
            run++;
        end
        if (!key && run == 3 * U && syms.len() > 0) begin
            r = decode(syms, 1'b1);
            rn = decode(syms, 1'b0);
            syms = "";
            armed = 1'b1;
            emit = 1'b1;
        end else if (!key && run == 7 * U && armed) begin
            r = {1'b0, 8'h20};
            rn = r;
            armed = 1'b0;
            emit = 1'b1;
        end
        if (emit) begin
            if (!mv || rdy) begin
                mv = 1'b1;
                {me, mc} = r;
                {men, mcn} = rn;
            end else begin
                mo = 1'b1;
            end
        end else if (rdy) begin
            mv = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        chk("valid", out_valid, mv);
        chk("char", out_char, mc);
        chk("err", out_err, me);
        chk("overrun", overrun, mo);
        chk("busy", busy, syms.len() > 0);
        chk("nd_valid", nd_valid, mv);
        chk("nd_char", nd_char, mcn);
        chk("nd_err", nd_err, men);
        chk("nd_overrun", nd_overrun, mo);
        chk("nd_busy", nd_busy, syms.len() > 0);
    end

    task automatic hold(input logic k, input int n);
        key = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            hold(1'b1, s[i] == 8'h2D ? 3 * U : U);
            if (i < s.len() - 1) hold(1'b0, U);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 8'h00);
        chk("rst_char", out_char, 8'h00);
        chk("rst_err", out_err, 8'h00);
        chk("rst_overrun", overrun, 8'h00);
        chk("rst_busy", busy, 8'h00);
        rst_n = 1'b1;
        hold(1'b0, 3);
        send(".-");
        chk("A_busy_before", busy, 8'h01);
        hold(1'b0, 11);
        chk("A_not_yet", out_valid, 8'h00);
        hold(1'b0, 1);
        chk("A_valid", out_valid, 8'h01);
        chk("A_char", out_char, 8'h41);
        chk("A_err", out_err, 8'h00);
        chk("A_busy_after", busy, 8'h00);
        rdy = 1'b1;
        hold(1'b0, 1);
        chk("A_consumed", out_valid, 8'h00);
        hold(1'b0, 14);
        chk("space_not_yet", out_valid, 8'h00);
        hold(1'b0, 1);
        chk("space_after_A", out_char, 8'h20);
        hold(1'b0, 10);
        send("...");
        hold(1'b0, 12);
        chk("S_char", out_char, 8'h53);
        hold(1'b0, 16);
        chk("S_space_valid", out_valid, 8'h01);
        chk("S_space_char", out_char, 8'h20);
        hold(1'b0, 1000);
        chk("quiet_valid", out_valid, 8'h00);
        send("-----");
        hold(1'b0, 12);
        chk("zero_char", out_char, 8'h30);
        chk("zero_err", out_err, 8'h00);
        chk("nd_zero_char", nd_char, 8'h3F);
        chk("nd_zero_err", nd_err, 8'h01);
        hold(1'b0, 30);
        send(".......");
        hold(1'b0, 12);
        chk("ovf_char", out_char, 8'h3F);
        chk("ovf_err", out_err, 8'h01);
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 12);
        chk("glitch_busy", busy, 8'h00);
        chk("glitch_valid", out_valid, 8'h00);
        hold(1'b0, 30);
        send(".");
        hold(1'b0, 2);
        hold(1'b1, 1);
        chk("glitch_mid_busy", busy, 8'h01);
        hold(1'b0, 2);
        send(".");
        hold(1'b0, 12);
        chk("I_char", out_char, 8'h49);
        hold(1'b0, 30);
        hold(1'b1, U / 2);
        hold(1'b0, 12);
        chk("half_unit_dot", out_char, 8'h45);
        hold(1'b0, 30);
        hold(1'b1, 2 * U - 1);
        hold(1'b0, U);
        hold(1'b1, 2 * U);
        hold(1'b0, 12);
        chk("dot_dash_edge", out_char, 8'h41);
        hold(1'b0, 30);
        rdy = 1'b0;
        send(".");
        hold(1'b0, 12);
        chk("E_held", out_char, 8'h45);
        send("-");
        hold(1'b0, 12);
        chk("T_dropped", out_char, 8'h45);
        chk("T_overrun", overrun, 8'h01);
        send("-.");
        hold(1'b0, 11);
        rdy = 1'b1;
        hold(1'b0, 1);
        chk("N_valid", out_valid, 8'h01);
        chk("N_char", out_char, 8'h4E);
        chk("overrun_sticky", overrun, 8'h01);
        hold(1'b0, 30);
        send(".-");
        hold(1'b0, 5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 8'h00);
        chk("mid_rst_char", out_char, 8'h00);
        chk("mid_rst_overrun", overrun, 8'h00);
        chk("mid_rst_busy", busy, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 40);
        chk("post_rst_valid", out_valid, 8'h00);
        chk("post_rst_busy", busy, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
